mbist_march_ctrl: RTL and testbench

MBIST_MARCH_CTRL -- requirements
Module: mbist_march_ctrl

---
 rtl/mbist_march_ctrl.sv | 129 ++++++++++++
 tb/tb_mbist_march_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mbist_march_ctrl.sv
// March C- memory BIST controller for a 64x8 synchronous SRAM.
// Stops on the first mismatch and reports its address and March element.
module mbist_march_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    output logic [5:0] ramaddr,
    output logic [7:0] ramin,
    output logic       rwbar,
    output logic       cs,
    input  logic [7:0] ramout,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [5:0] fail_addr,
    output logic [2:0] fail_elem
);

    typedef enum logic [2:0] {StIdle, StWr, StRd, StCmp, StDone} state_e;

    state_e     state_q, state_d;
    logic [2:0] elem_q, elem_d;
    logic [5:0] addr_q, addr_d;
    logic       fail_q, fail_d;
    logic [5:0] fail_addr_q, fail_addr_d;
    logic [2:0] fail_elem_q, fail_elem_d;

    logic       down;
    logic       last_addr;
    logic [7:0] exp_rd;
    logic [7:0] wr_val;

    always_comb begin
        down      = (elem_q == 3'd3) || (elem_q == 3'd4);
        last_addr = down ? (addr_q == 6'd0) : (addr_q == 6'd63);
        exp_rd    = ((elem_q == 3'd2) || (elem_q == 3'd4)) ? 8'hFF : 8'h00;
        wr_val    = ((elem_q == 3'd1) || (elem_q == 3'd3)) ? 8'hFF : 8'h00;
    end

    always_comb begin
        state_d     = state_q;
        elem_d      = elem_q;
        addr_d      = addr_q;
        fail_d      = fail_q;
        fail_addr_d = fail_addr_q;
        fail_elem_d = fail_elem_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StWr;
                    elem_d  = 3'd0;
                    addr_d  = 6'd0;
                end
            end
            StWr: begin
                if (last_addr) begin
                    // E3 and E4 run downward, so they start at the top address.
                    elem_d  = elem_q + 3'd1;
                    addr_d  = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? 6'd63 : 6'd0;
                    state_d = StRd;
                end else begin
                    addr_d  = down ? addr_q - 6'd1 : addr_q + 6'd1;
                    state_d = (elem_q == 3'd0) ? StWr : StRd;
                end
            end
            StRd: state_d = StCmp;
            StCmp: begin
                if (ramout != exp_rd) begin
                    fail_d      = 1'b1;
                    fail_addr_d = addr_q;
                    fail_elem_d = elem_q;
                    state_d     = StDone;
                end else if (elem_q == 3'd5) begin
                    if (last_addr) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + 6'd1;
                        state_d = StRd;
                    end
                end else begin
                    state_d = StWr;
                end
            end
            StDone: begin
                if (start) begin
                    fail_d      = 1'b0;
                    fail_addr_d = 6'd0;
                    fail_elem_d = 3'd0;
                    elem_d      = 3'd0;
                    addr_d      = 6'd0;
                    state_d     = StWr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            elem_q      <= 3'd0;
            addr_q      <= 6'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= 6'd0;
            fail_elem_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            elem_q      <= elem_d;
            addr_q      <= addr_d;
            fail_q      <= fail_d;
            fail_addr_q <= fail_addr_d;
            fail_elem_q <= fail_elem_d;
        end
    end

    // Bus signals are decoded from registered state only.
    always_comb begin
        cs        = (state_q == StWr) || (state_q == StRd) || (state_q == StCmp);
        busy      = cs;
        rwbar     = (state_q != StWr);
        ramin     = (state_q == StWr) ? wr_val : 8'h00;
        ramaddr   = addr_q;
        done      = (state_q == StDone);
        fail      = fail_q;
        fail_addr = fail_addr_q;
        fail_elem = fail_elem_q;
    end

endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: SRAM model with an injectable stuck-at bit and
// an array-based March C- reference that predicts the bus trace and result.
module tb_mbist_march_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] ramaddr;
    logic [7:0] ramin;
    logic       rwbar;
    logic       cs;
    logic [7:0] ramout = 8'h00;
    logic       busy;
    logic       done;
    logic       fail;
    logic [5:0] fail_addr;
    logic [2:0] fail_elem;

    int checks = 0;
    int failures = 0;

    mbist_march_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .ramaddr   (ramaddr),
        .ramin     (ramin),
        .rwbar     (rwbar),
        .cs        (cs),
        .ramout    (ramout),
        .busy      (busy),
        .done      (done),
        .fail      (fail),
        .fail_addr (fail_addr),
        .fail_elem (fail_elem)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       wr;
        logic [5:0] a;
        logic [7:0] d;
    } op_t;

    localparam logic [27:0] RST_VEC = {6'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 3'd0};

    // Fault injection state
    bit       f_en = 1'b0;
    bit [5:0] f_addr = 6'd0;
    int       f_bit = 0;
    bit       f_val = 1'b0;
    bit [7:0] mem [64];

    function automatic bit [7:0] flt(input bit [5:0] a, input bit [7:0] d);
        bit [7:0] r;
        r = d;
        if (f_en && a == f_addr) r[f_bit] = f_val;
        return r;
    endfunction

    always @(posedge clk) begin
        if (cs && !rwbar) mem[ramaddr] <= flt(ramaddr, ramin);
        if (cs && rwbar) ramout <= flt(ramaddr, mem[ramaddr]);
        else ramout <= 8'h00;
    end

    // Reference model
    op_t exp_q[$];
    int  exp_cycles;
    bit  exp_fail;
    int  exp_faddr;
    int  exp_felem;

    task automatic build_model();
        bit [7:0] m [64];
        bit [7:0] rexp [6];
        bit [7:0] wexp [6];
        rexp = '{8'h00, 8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00};
        wexp = '{8'h00, 8'hFF, 8'h00, 8'hFF, 8'h00, 8'h00};
        exp_q.delete();
        exp_cycles = 0;
        exp_fail = 1'b0;
        exp_faddr = 0;
        exp_felem = 0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < 64; k++) begin
                bit [5:0] a;
                bit [7:0] rd;
                a = (e == 3 || e == 4) ? 6'(63 - k) : 6'(k);
                if (e > 0) begin
                    rd = flt(a, m[a]);
                    exp_q.push_back('{1'b0, a, rd});
                    exp_cycles += 2;
                    if (rd != rexp[e]) begin
                        exp_fail = 1'b1;
                        exp_faddr = a;
                        exp_felem = e;
                        return;
                    end
                end
                if (e < 5) begin
                    m[a] = flt(a, wexp[e]);
                    exp_q.push_back('{1'b1, a, wexp[e]});
                    exp_cycles += 1;
                end
            end
        end
    endtask

    // Bus monitor results
    op_t dut_q[$];
    int  busy_cyc;
    bit  got_done;
    int  prot_err;

    function automatic int trace_diff();
        int n;
        n = (dut_q.size() < exp_q.size()) ? dut_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (dut_q[i] !== exp_q[i]) return i;
        if (dut_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    // mode 0: start low, 1: random start while busy, 2: leave start alone
    task automatic monitor_run(input int budget, input int mode);
        bit rd_phase = 1'b0;
        logic [5:0] rd_addr = 6'd0;
        dut_q.delete();
        busy_cyc = 0;
        got_done = 1'b0;
        prot_err = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cyc++;
            if (busy !== cs) prot_err++;
            if (cs && rwbar && ramin !== 8'h00) prot_err++;
            if (cs && !rwbar) begin
                dut_q.push_back('{1'b1, ramaddr, ramin});
                rd_phase = 1'b0;
            end else if (cs && rwbar) begin
                if (!rd_phase) begin
                    rd_addr = ramaddr;
                    rd_phase = 1'b1;
                end else begin
                    dut_q.push_back('{1'b0, rd_addr, ramout});
                    if (ramaddr !== rd_addr) prot_err++;
                    rd_phase = 1'b0;
                end
            end else begin
                rd_phase = 1'b0;
            end
            if (mode == 0) start = 1'b0;
            else if (mode == 1) start = busy ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        if (mode != 2) start = 1'b0;
    endtask

    task automatic pulse_and_run(input int mode);
        @(negedge clk);
        start = 1'b1;
        monitor_run(2000, mode);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ramaddr, ramin, rwbar, cs, busy, done, fail, fail_addr, fail_elem} !== RST_VEC) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=%h",
                     {ramaddr, ramin, rwbar, cs, busy, done, fail, fail_addr, fail_elem}, RST_VEC);
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, cs, done} !== 3'b000) begin
            failures++;
            $display("FAIL idle_after_reset got busy/cs/done=%b want=000", {busy, cs, done});
        end
    endtask

    task automatic test_clean_run();
        f_en = 1'b0;
        build_model();
        pulse_and_run(0);
        checks++;
        if (busy_cyc != 960 || !got_done) begin
            failures++;
            $display("FAIL clean_busy_cycles got=%0d done=%0b want=960 done=1", busy_cyc, got_done);
        end
        checks++;
        if ({done, fail, cs} !== 3'b100) begin
            failures++;
            $display("FAIL clean_result got done/fail/cs=%b want=100", {done, fail, cs});
        end
        checks++;
        if (trace_diff() != -1 || dut_q.size() != 640) begin
            failures++;
            $display("FAIL clean_trace first_diff=%0d ops=%0d want diff=-1 ops=640",
                     trace_diff(), dut_q.size());
        end
        checks++;
        if (prot_err != 0) begin
            failures++;
            $display("FAIL clean_protocol got=%0d violations want=0", prot_err);
        end
    endtask

    task automatic test_e3_order();
        int bad = 0;
        f_en = 1'b0;
        pulse_and_run(0);
        checks++;
        if (dut_q.size() < 448) begin
            failures++;
            $display("FAIL e3_trace_len got=%0d want>=448", dut_q.size());
        end else begin
            if (dut_q[320] !== op_t'({1'b0, 6'd63, 8'h00})) bad++;
            if (dut_q[321] !== op_t'({1'b1, 6'd63, 8'hFF})) bad++;
            for (int i = 0; i < 64; i++) begin
                if (dut_q[320 + 2 * i].a !== 6'(63 - i)) bad++;
                if (dut_q[321 + 2 * i] !== op_t'({1'b1, 6'(63 - i), 8'hFF})) bad++;
            end
            if (bad != 0) begin
                failures++;
                $display("FAIL e3_order got %0d bad ops (first op %h, %h) want 0 (0,63,00 then 1,63,ff)",
                         bad, dut_q[320], dut_q[321]);
            end
        end
    endtask

    task automatic test_stuck(input bit [5:0] a, input int b, input bit v,
                              input int want_elem, input string tag);
        f_en = 1'b1;
        f_addr = a;
        f_bit = b;
        f_val = v;
        build_model();
        pulse_and_run(0);
        checks++;
        if ({done, fail, fail_addr, fail_elem} !== {1'b1, 1'b1, a, 3'(want_elem)}) begin
            failures++;
            $display("FAIL %s_result got done=%0b fail=%0b addr=%0d elem=%0d want 1 1 %0d %0d",
                     tag, done, fail, fail_addr, fail_elem, a, want_elem);
        end
        checks++;
        if (busy_cyc != exp_cycles || trace_diff() != -1) begin
            failures++;
            $display("FAIL %s_trace got cycles=%0d diff=%0d want cycles=%0d diff=-1",
                     tag, busy_cyc, trace_diff(), exp_cycles);
        end
        f_en = 1'b0;
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            f_en = ($urandom_range(0, 3) != 0);
            f_addr = 6'($urandom_range(0, 63));
            f_bit = $urandom_range(0, 7);
            f_val = 1'($urandom_range(0, 1));
            build_model();
            pulse_and_run(1);
            checks++;
            if (!got_done || busy_cyc != exp_cycles) begin
                failures++;
                $display("FAIL rand%0d_cycles got=%0d done=%0b want=%0d", it, busy_cyc,
                         got_done, exp_cycles);
            end
            checks++;
            if (fail !== exp_fail || (exp_fail && (fail_addr !== 6'(exp_faddr) ||
                                                   fail_elem !== 3'(exp_felem)))) begin
                failures++;
                $display("FAIL rand%0d_result got fail=%0b addr=%0d elem=%0d want %0b %0d %0d",
                         it, fail, fail_addr, fail_elem, exp_fail, exp_faddr, exp_felem);
            end
            checks++;
            if (trace_diff() != -1 || prot_err != 0) begin
                failures++;
                $display("FAIL rand%0d_trace got diff=%0d prot=%0d want -1 0", it,
                         trace_diff(), prot_err);
            end
        end
        f_en = 1'b0;
    endtask

    task automatic test_mid_reset();
        int writes = 0;
        f_en = 1'b0;
        @(negedge clk);
        start = 1'b1;
        monitor_run(300, 0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ramaddr, ramin, rwbar, cs, busy, done, fail, fail_addr, fail_elem} !== RST_VEC) begin
            failures++;
            $display("FAIL midreset_outputs got=%h want=%h",
                     {ramaddr, ramin, rwbar, cs, busy, done, fail, fail_addr, fail_elem}, RST_VEC);
        end
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 4) rst_n = 1'b1;
            if (cs || busy) writes++;
        end
        checks++;
        if (writes != 0) begin
            failures++;
            $display("FAIL midreset_quiet got=%0d active cycles want=0", writes);
        end
        build_model();
        pulse_and_run(0);
        checks++;
        if (busy_cyc != 960 || fail !== 1'b0 || done !== 1'b1 || trace_diff() != -1) begin
            failures++;
            $display("FAIL midreset_rerun got cycles=%0d fail=%0b done=%0b diff=%0d want 960 0 1 -1",
                     busy_cyc, fail, done, trace_diff());
        end
    endtask

    task automatic test_start_held();
        f_en = 1'b1;
        f_addr = 6'd5;
        f_bit = 3;
        f_val = 1'b1;
        build_model();
        @(negedge clk);
        start = 1'b1;
        monitor_run(2000, 2);
        checks++;
        if (!got_done || busy_cyc != exp_cycles || fail !== 1'b1) begin
            failures++;
            $display("FAIL held_first_run got cycles=%0d done=%0b fail=%0b want %0d 1 1",
                     busy_cyc, got_done, fail, exp_cycles);
        end
        @(negedge clk);
        checks++;
        if ({busy, done, fail, fail_addr, fail_elem} !== {1'b1, 1'b0, 1'b0, 6'd0, 3'd0}) begin
            failures++;
            $display("FAIL held_restart got busy=%0b done=%0b fail=%0b addr=%0d elem=%0d want 1 0 0 0 0",
                     busy, done, fail, fail_addr, fail_elem);
        end
        start = 1'b0;
        monitor_run(2000, 0);
        checks++;
        if (!got_done || fail !== 1'b1 || fail_addr !== 6'd5 || fail_elem !== 3'd1) begin
            failures++;
            $display("FAIL held_second_run got done=%0b fail=%0b addr=%0d elem=%0d want 1 1 5 1",
                     got_done, fail, fail_addr, fail_elem);
        end
        f_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_e3_order();
        test_stuck(6'd17, 0, 1'b1, 1, "stuck1_a17");
        test_stuck(6'd40, 7, 1'b0, 2, "stuck0_a40");
        test_random();
        test_mid_reset();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
